mlp_result_tx: RTL
==================

# mlp_result_tx

Output-side transmitter of the MLP accelerator's 32-bit result stream. It collects the 16×16 matrix of 16-bit results, which the PE array produces two rows per round, into a frame buffer. Once all eight row-pairs are present, it serializes the frame as 128 words of 32 bits on `result_valid_o`/`result_payload_o` with a ready handshake. It sits between the PE-array rounder output and the accelerator's result port; it is the counterpart of the 32-bit load stream consumed by the data loader.

## Interface
- `ROWS`, 16, matrix rows
- `COLS`, 16, matrix columns
- `DW`, 16, element width in bits; output word is 2·DW
- `RPR`, 2, rows delivered per round; the number of rounds is ROWS/RPR = 8

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pair_valid_i`  in  1  one row-pair offered this cycle
- `pair_idx_i`  in  3  row-pair index; rows 2·idx and 2·idx+1
- `pair_data_i`  in  RPR·COLS·DW (512)  bits [DW·(r·COLS+c) +: DW] = element(row 2·idx+r, col c)
- `tx_busy_o`  out  1  high in STREAM; upstream must not offer pairs
- `result_valid_o`  out  1  output word valid
- `result_ready_i`  in  1  sink accepts the word
- `result_payload_o`  out  2·DW (32)  output word
- `frame_done_o`  out  1  one-cycle pulse on acceptance of the last word
- `overrun_o`  out  1  sticky flag: a pair was offered during STREAM

## Operation
- State machine with states COLLECT and STREAM. Reset state is COLLECT.
- COLLECT:
  - When `pair_valid_i` is high, write both rows into the buffer at `pair_idx_i` and set `mask[pair_idx_i]`.
  - A repeated index overwrites the buffer data and leaves the mask unchanged.
  - When the mask, including the write in the current cycle, equals 8'hFF, move to STREAM on the next edge. At that edge the word counter is 0 and the mask is cleared.
- STREAM:
  - `result_valid_o` = 1.
  - Word k (0..127): r = k/8, c = k%8, payload = {elem[r][2c+1], elem[r][2c]}. Row-major order; the lower column goes in the low half.
  - On `result_valid_o & result_ready_i`, k increments.
  - On the handshake of k = 127: `frame_done_o` pulses, the state returns to COLLECT, and k resets to 0.
  - `pair_valid_i` high in STREAM: the data is dropped, the buffer and mask are untouched, and `overrun_o` is set. `overrun_o` clears only on `rst`.
- The buffer is not cleared between frames. A new frame fully overwrites it, because all 8 pairs are required before streaming.
- No arithmetic is performed; elements pass bit-exact.

## Timing
- Reset values: `result_valid_o` = 0, `result_payload_o` = 0, `tx_busy_o` = 0, `frame_done_o` = 0, `overrun_o` = 0, mask = 0, k = 0, buffer = 0.
- Reset is asynchronous. Asserting `rst` mid-stream drops `result_valid_o` immediately and discards the partial frame.
- Latency:
  - The final pair is written at edge N.
  - `result_valid_o` = 1 with word 0 from edge N (the cycle after the write is presented).
  - A minimum of 128 cycles streams a frame when `result_ready_i` is held at 1.
- `result_valid_o`, `tx_busy_o` and `frame_done_o` are registered state decodes.
- `result_payload_o` is a mux of the buffer by k. It is stable while valid and not ready.
- Valid never drops before its handshake.
- Sink stall: `result_ready_i` = 0 holds k and the payload indefinitely.
- Back-to-back frames: the first pair of the next frame may be offered in the cycle after `frame_done_o`.

## Configuration
- `MLP_RESULT_TX_HDR_EN`
  - **Defined:** each frame is preceded by a header word {16'hA5A5, 8'h00, frame_cnt[7:0]}. The stream is 129 words; the header is k = 0 and data word j is sent at k = j+1. `frame_done_o` fires on k = 128. `frame_cnt` resets to 0, increments on each `frame_done_o`, and wraps 255→0.
  - **Undefined:** there is no header and no counter; the stream is 128 words exactly as in Operation.

## Test plan
- **Basic frame.** Stimulus: elem[r][c] = {r[7:0], c[7:0]}; pairs 0..7 in order; ready held at 1. Required response: word 0 = 32'h0001_0000, word 9 = 32'h0103_0102, word 127 = 32'h0F0F_0F0E; `frame_done_o` on the 128th handshake.
- **Out-of-order and duplicate pairs.** Stimulus: order 7,3,3,0,1,2,4,5,6, where the second pair-3 carries 16'hBEEF in all its elements. Required response: STREAM is entered only after the last new index; words 48..63 = 32'hBEEF_BEEF.
- **Backpressure.** Stimulus: ready toggles 1,0,0,1 repeatedly. Required response: the payload holds while ready = 0, no word is skipped or duplicated, and all 128 words arrive.
- **Overrun.** Stimulus: offer `pair_valid_i` during STREAM. Required response: `overrun_o` = 1 and stays 1; the streamed data is unchanged; the next frame's mask is unaffected.
- **Reset mid-stream.** Stimulus: assert `rst` at word 40. Required response: valid goes 0 asynchronously; after release, a new 8-pair frame streams from word 0.
- **With `MLP_RESULT_TX_HDR_EN` defined.** Stimulus: two frames. Required response: headers 32'hA5A5_0000 then 32'hA5A5_0001; 129 words per frame.

Source files
------------

// File: rtl/mlp_result_tx.sv
// Result-stream transmitter: gathers row-pairs of the PE-array output into a frame
// buffer, then streams the frame as 2*DW-bit words. Optional header: MLP_RESULT_TX_HDR_EN.
module mlp_result_tx #(
    parameter int ROWS = 16,
    parameter int COLS = 16,
    parameter int DW   = 16,
    parameter int RPR  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pair_valid_i,
    input  logic [2:0]               pair_idx_i,
    input  logic [RPR*COLS*DW-1:0]   pair_data_i,
    output logic                     tx_busy_o,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [2*DW-1:0]          result_payload_o,
    output logic                     frame_done_o,
    output logic                     overrun_o
);

    localparam int NPAIR = ROWS / RPR;
    localparam int PW    = RPR * COLS * DW;
    localparam int WW    = 2 * DW;
    localparam int WPP   = (RPR * COLS) / 2;
    localparam int NDATA = NPAIR * WPP;
`ifdef MLP_RESULT_TX_HDR_EN
    localparam int NWORDS = NDATA + 1;
`else
    localparam int NWORDS = NDATA;
`endif
    localparam int KW = $clog2(NWORDS);
    localparam int JW = $clog2(NDATA);
    localparam int SW = $clog2(WPP);
    localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

    typedef enum logic {S_COLLECT, S_STREAM} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PW-1:0]       r_buf [NPAIR];
    logic [NPAIR-1:0]    r_mask;
    logic [KW-1:0]       r_k;
    logic                r_done;
    logic                r_overrun;

    logic [NPAIR-1:0]    w_onehot;
    logic [NPAIR-1:0]    w_mask_set;
    logic                w_wr;
    logic                w_last_hs;
    logic [JW-1:0]       w_j;
    logic [JW-SW-1:0]    w_pair;
    logic [SW-1:0]       w_sub;
    logic [PW-1:0]       w_buf;
    logic [WW-1:0]       w_word;

    assign w_onehot   = NPAIR'(1) << pair_idx_i;
    assign w_mask_set = r_mask | w_onehot;
    assign w_wr       = pair_valid_i && (r_state == S_COLLECT);
    assign w_last_hs  = (r_state == S_STREAM) && result_ready_i && (r_k == K_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_COLLECT;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_COLLECT: if (pair_valid_i && (w_mask_set == '1)) w_state_next = S_STREAM;
            S_STREAM:  if (w_last_hs) w_state_next = S_COLLECT;
            default:   w_state_next = S_COLLECT;
        endcase
    end

    // Buffer is only written while collecting; pairs offered during STREAM are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NPAIR; i++) r_buf[i] <= '0;
        end else begin
            for (int i = 0; i < NPAIR; i++) begin
                if (w_wr && w_onehot[i]) r_buf[i] <= pair_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask    <= '0;
            r_k       <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done <= w_last_hs;
            if (r_state == S_COLLECT) begin
                r_k <= '0;
                if (pair_valid_i) r_mask <= (w_mask_set == '1) ? '0 : w_mask_set;
            end else begin
                if (pair_valid_i) r_overrun <= 1'b1;
                if (result_ready_i) r_k <= (r_k == K_LAST) ? '0 : r_k + KW'(1);
            end
        end
    end

`ifdef MLP_RESULT_TX_HDR_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_frame_cnt <= '0;
        else if (w_last_hs) r_frame_cnt <= r_frame_cnt + 8'd1;
    end

    assign w_j = JW'(r_k - KW'(1));
`else
    assign w_j = JW'(r_k);
`endif

    // Word j lives in pair j/WPP; within a pair the words are already contiguous.
    assign w_pair = w_j[JW-1:SW];
    assign w_sub  = w_j[SW-1:0];
    assign w_buf  = r_buf[w_pair];

`ifdef MLP_RESULT_TX_HDR_EN
    assign w_word = (r_k == '0) ? WW'({16'hA5A5, 8'h00, r_frame_cnt}) : w_buf[w_sub*WW +: WW];
`else
    assign w_word = w_buf[w_sub*WW +: WW];
`endif

    assign result_valid_o   = (r_state == S_STREAM);
    assign tx_busy_o        = (r_state == S_STREAM);
    assign result_payload_o = result_valid_o ? w_word : '0;
    assign frame_done_o     = r_done;
    assign overrun_o        = r_overrun;

endmodule
